// File: rtl/draw_sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : draw_pkg
//  Purpose  : Shared constants and FSM state encoding for the sprite blitter.
//             Screen geometry, sprite size, transparent colour key.
//  Revision : 1.0  initial release
// ============================================================================
package draw_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int SPRITE_DIM = 16;

    localparam logic [7:0] TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_e;

endpackage : draw_pkg
`default_nettype wire

// File: rtl/draw_sprite_if.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sprite_if
//  Purpose  : Request handshake, sprite ROM port and frame-buffer write port
//             of the sprite blitter, bundled in one interface.
//  Ports    : master = initiator/ROM/frame-buffer side
//             slave  = draw_sprite block side
//  Revision : 1.0  initial release
// ============================================================================
interface draw_sprite_if;

    logic        draw_sprite_start;
    logic [7:0]  draw_sprite_image;
    logic [16:0] draw_sprite_coordinates;   // {x[8:0], y[7:0]}
    logic        draw_sprite_rdy;

    logic        sprite_rom_re;
    logic [15:0] sprite_rom_addr;           // {image, row, col}
    logic [7:0]  sprite_rom_data;

    logic        fb_we;
    logic [16:0] fb_addr;                   // {py[7:0], px[8:0]}
    logic [7:0]  fb_data;

    modport slave (
        input  draw_sprite_start,
        input  draw_sprite_image,
        input  draw_sprite_coordinates,
        output draw_sprite_rdy,
        output sprite_rom_re,
        output sprite_rom_addr,
        input  sprite_rom_data,
        output fb_we,
        output fb_addr,
        output fb_data
    );

    modport master (
        output draw_sprite_start,
        output draw_sprite_image,
        output draw_sprite_coordinates,
        input  draw_sprite_rdy,
        input  sprite_rom_re,
        input  sprite_rom_addr,
        output sprite_rom_data,
        input  fb_we,
        input  fb_addr,
        input  fb_data
    );

endinterface : draw_sprite_if
`default_nettype wire

// File: rtl/pixel_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_counter
//  Purpose  : 8-bit pixel index walking the 16x16 sprite in raster order.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             clr_i      - force index to zero (takes priority over inc_i)
//             inc_i      - advance index by one (wraps 255 -> 0)
//             idx_o      - current index {row[3:0], col[3:0]}
//             last_o     - index is 255 (final pixel of the sprite)
//  Revision : 1.0  initial release
// ============================================================================
module pixel_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] idx_o,
    output logic       last_o
);

    logic [7:0] idx_q;
    logic [7:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = 8'd0;
        end else if (inc_i) begin
            idx_d = idx_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 8'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == 8'hFF);

endmodule : pixel_counter
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sprite
//  Purpose  : Blits one 16x16 sprite from an external image ROM into an
//             external frame buffer. One ROM read per cycle; a single
//             pipeline stage pairs each returned colour with its screen
//             position. Transparent pixels are skipped and, with CLIP_EN=1,
//             off-screen pixels are suppressed.
//  Params   : CLIP_EN     - 1: drop pixels outside 320x240; 0: write all
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             sprite_bus  - request handshake, ROM port, frame-buffer port
//  Revision : 1.0  initial release
// ============================================================================
module draw_sprite
    import draw_pkg::*;
#(
    parameter bit CLIP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    draw_sprite_if.slave  sprite_bus
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e      state_q;
    logic        rdy_q;
    logic        re_q;
    logic [7:0]  image_q;
    logic [8:0]  x0_q;
    logic [7:0]  y0_q;

    // Pipeline stage travelling alongside the ROM read latency
    logic        pv_q;
    logic [9:0]  px_q;      // one extra bit so x0+col never wraps
    logic [8:0]  py_q;      // one extra bit so y0+row never wraps

    logic        w_accept;
    logic        w_cnt_inc;
    logic [7:0]  w_idx;
    logic        w_idx_last;
    logic        w_on_screen;
    logic        w_wr;

    assign w_accept  = (state_q == IDLE) && sprite_bus.draw_sprite_start;
    assign w_cnt_inc = (state_q == READ);

    pixel_counter u_pixel_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_accept),
        .inc_i  (w_cnt_inc),
        .idx_o  (w_idx),
        .last_o (w_idx_last)
    );

    // ------------------------------------------------------------------
    // Control FSM and pipeline stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            re_q    <= 1'b0;
            image_q <= 8'd0;
            x0_q    <= 9'd0;
            y0_q    <= 8'd0;
            pv_q    <= 1'b0;
            px_q    <= 10'd0;
            py_q    <= 9'd0;
        end else begin
            // The position of the pixel read this cycle is captured so it
            // lines up with the ROM data returning next cycle.
            pv_q <= re_q;
            px_q <= {1'b0, x0_q} + {6'd0, w_idx[3:0]};
            py_q <= {1'b0, y0_q} + {5'd0, w_idx[7:4]};

            case (state_q)
                IDLE: begin
                    if (sprite_bus.draw_sprite_start) begin
                        image_q <= sprite_bus.draw_sprite_image;
                        x0_q    <= sprite_bus.draw_sprite_coordinates[16:8];
                        y0_q    <= sprite_bus.draw_sprite_coordinates[7:0];
                        state_q <= READ;
                        rdy_q   <= 1'b0;
                        re_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (w_idx_last) begin
                        state_q <= LAST;
                        re_q    <= 1'b0;
                    end
                end
                LAST: begin
                    // Only the write of pixel 255 remains; it drains from
                    // the pipeline stage this cycle.
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    re_q    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Clipping
    // ------------------------------------------------------------------
    generate
        if (CLIP_EN) begin : g_clip
            assign w_on_screen = (px_q < 10'(SCREEN_W)) && (py_q < 9'(SCREEN_H));
        end else begin : g_noclip
            assign w_on_screen = 1'b1;
        end
    endgenerate

    // A stage still pending while rst is asserted is dropped immediately.
    assign w_wr = pv_q && !rst && w_on_screen
               && (sprite_bus.sprite_rom_data != TRANSPARENT);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sprite_bus.draw_sprite_rdy = rdy_q;
    assign sprite_bus.sprite_rom_re   = re_q;
    assign sprite_bus.sprite_rom_addr = {image_q, w_idx};
    assign sprite_bus.fb_we           = w_wr;
    assign sprite_bus.fb_addr         = w_wr ? {py_q[7:0], px_q[8:0]} : 17'd0;
    assign sprite_bus.fb_data         = w_wr ? sprite_bus.sprite_rom_data : 8'd0;

endmodule : draw_sprite
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_sprite
//  Purpose  : Directed self-checking bench for draw_sprite. Two instances
//             (clipping on and off) share the same request stimulus; each
//             has its own ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_sprite;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] img = 8'd0;
    logic [8:0] xin = 9'd0;
    logic [7:0] yin = 8'd0;
    int         mode = 0;

    always #5 clk = ~clk;

    draw_sprite_if ifc1 ();
    draw_sprite_if ifc0 ();

    assign ifc1.draw_sprite_start       = start;
    assign ifc1.draw_sprite_image       = img;
    assign ifc1.draw_sprite_coordinates = {xin, yin};
    assign ifc0.draw_sprite_start       = start;
    assign ifc0.draw_sprite_image       = img;
    assign ifc0.draw_sprite_coordinates = {xin, yin};

    draw_sprite #(.CLIP_EN(1'b1)) u_dut1 (.clk(clk), .rst(rst), .sprite_bus(ifc1.slave));
    draw_sprite #(.CLIP_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .sprite_bus(ifc0.slave));

    // Sprite content as a function of pattern mode and pixel position
    function automatic logic [7:0] pat(input int m, input logic [3:0] r, input logic [3:0] c);
        case (m)
            0:       pat = 8'hFF;
            1:       pat = (r[0] ^ c[0]) ? 8'h3C : 8'h00;
            2:       pat = {r, c} | 8'h01;
            default: pat = 8'h00;
        endcase
    endfunction

    // ROM models: data one cycle after the read enable
    always @(posedge clk) begin
        ifc1.sprite_rom_data <= ifc1.sprite_rom_re ?
            pat(mode, ifc1.sprite_rom_addr[7:4], ifc1.sprite_rom_addr[3:0]) : 8'h00;
        ifc0.sprite_rom_data <= ifc0.sprite_rom_re ?
            pat(mode, ifc0.sprite_rom_addr[7:4], ifc0.sprite_rom_addr[3:0]) : 8'h00;
    end

    logic        we_a [2];
    logic [16:0] fa_a [2];
    logic [7:0]  fd_a [2];
    logic        re_a [2];
    logic [15:0] ra_a [2];
    assign we_a[0] = ifc0.fb_we;   assign we_a[1] = ifc1.fb_we;
    assign fa_a[0] = ifc0.fb_addr; assign fa_a[1] = ifc1.fb_addr;
    assign fd_a[0] = ifc0.fb_data; assign fd_a[1] = ifc1.fb_data;
    assign re_a[0] = ifc0.sprite_rom_re;   assign re_a[1] = ifc1.sprite_rom_re;
    assign ra_a[0] = ifc0.sprite_rom_addr; assign ra_a[1] = ifc1.sprite_rom_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ex_x0 = 0;
    int ex_y0 = 0;
    int wr_cnt [2], rd_cnt [2], zero_cnt [2], bad_cnt [2];
    int pxmin [2], pxmax [2], pymin [2], pymax [2], admin [2], admax [2];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; rd_cnt[d] = 0; zero_cnt[d] = 0; bad_cnt[d] = 0;
            pxmin[d] = 100000; pxmax[d] = -1; pymin[d] = 100000; pymax[d] = -1;
            admin[d] = 100000; admax[d] = -1;
        end
    endtask

    task automatic sample();
        int px, py, dr, dc;
        for (int d = 0; d < 2; d++) begin
            if (we_a[d] === 1'b1) begin
                wr_cnt[d]++;
                px = int'(fa_a[d][8:0]);
                py = int'(fa_a[d][16:9]);
                if (px < pxmin[d]) pxmin[d] = px;
                if (px > pxmax[d]) pxmax[d] = px;
                if (py < pymin[d]) pymin[d] = py;
                if (py > pymax[d]) pymax[d] = py;
                if (fd_a[d] == 8'h00) zero_cnt[d]++;
                dc = px - ex_x0;
                dr = py - ex_y0;
                if (dc < 0 || dc > 15 || dr < 0 || dr > 15 ||
                    fd_a[d] !== pat(mode, 4'(dr), 4'(dc)))
                    bad_cnt[d]++;
            end
            if (re_a[d] === 1'b1) begin
                rd_cnt[d]++;
                if (int'(ra_a[d]) < admin[d]) admin[d] = int'(ra_a[d]);
                if (int'(ra_a[d]) > admax[d]) admax[d] = int'(ra_a[d]);
            end
        end
    endtask

    // Advance one cycle and observe the DUTs 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    logic        c2_we;
    logic [16:0] c2_addr;

    // Accept a sprite in the current cycle and run until rdy returns.
    // lat counts cycles from the accept cycle to the first rdy cycle.
    task automatic run_sprite(input logic [7:0] i, input logic [8:0] x,
                              input logic [7:0] y, output int lat);
        clear_stats();
        ex_x0 = int'(x);
        ex_y0 = int'(y);
        img = i; xin = x; yin = y;
        check("rdy_at_accept", ifc1.draw_sprite_rdy, 1);
        start = 1'b1;
        step();
        check("first_read_addr", {ifc1.sprite_rom_re, ifc1.sprite_rom_addr}, {1'b1, i, 8'h00});
        start = 1'b0;
        step();
        c2_we   = ifc0.fb_we;
        c2_addr = ifc0.fb_addr;
        lat = 2;
        while (ifc1.draw_sprite_rdy !== 1'b1 && lat < 600) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, acc0, n;

        // ---------------- reset state ----------------
        clear_stats();
        rst = 1'b1;
        repeat (3) step();
        check("rst_rdy",     ifc1.draw_sprite_rdy, 1);
        check("rst_rom_re",  ifc1.sprite_rom_re, 0);
        check("rst_fb_we",   ifc1.fb_we, 0);
        check("rst_fb_addr", ifc1.fb_addr, 0);
        check("rst_fb_data", ifc1.fb_data, 0);
        rst = 1'b0;
        step();

        // ---------------- solid sprite at (10,20) ----------------
        mode = 0;
        run_sprite(8'h05, 9'd10, 8'd20, lat);
        check("s1_latency", lat, 258);
        check("s1_pix0_write", {c2_we, c2_addr}, {1'b1, 8'd20, 9'd10});
        check("s1_writes",  wr_cnt[1], 256);
        check("s1_pxmin",   pxmin[1], 10);
        check("s1_pxmax",   pxmax[1], 25);
        check("s1_pymin",   pymin[1], 20);
        check("s1_pymax",   pymax[1], 35);
        check("s1_reads",   rd_cnt[1], 256);
        check("s1_admin",   admin[1], 16'h0500);
        check("s1_admax",   admax[1], 16'h05FF);
        check("s1_bad",     bad_cnt[1], 0);

        // ---------------- checkerboard ----------------
        mode = 1;
        run_sprite(8'h07, 9'd100, 8'd50, lat);
        check("s2_latency", lat, 258);
        check("s2_writes",  wr_cnt[1], 128);
        check("s2_zero",    zero_cnt[1], 0);
        check("s2_bad",     bad_cnt[1], 0);

        // ---------------- bottom-right corner, clip on/off ----------------
        mode = 0;
        run_sprite(8'h11, 9'd312, 8'd232, lat);
        check("s3_latency",     lat, 258);
        check("s3_clip_writes", wr_cnt[1], 64);
        check("s3_clip_pxmin",  pxmin[1], 312);
        check("s3_clip_pxmax",  pxmax[1], 319);
        check("s3_clip_pymin",  pymin[1], 232);
        check("s3_clip_pymax",  pymax[1], 239);
        check("s3_clip_bad",    bad_cnt[1], 0);
        check("s3_nc_writes",   wr_cnt[0], 256);
        check("s3_nc_pxmax",    pxmax[0], 327);
        check("s3_nc_pymax",    pymax[0], 247);

        // ---------------- fully off-screen ----------------
        run_sprite(8'h12, 9'd400, 8'd100, lat);
        check("s4_latency",     lat, 258);
        check("s4_clip_writes", wr_cnt[1], 0);
        check("s4_nc_writes",   wr_cnt[0], 256);

        // ---------------- fully transparent ----------------
        mode = 3;
        run_sprite(8'h13, 9'd30, 8'd30, lat);
        check("s5_latency", lat, 258);
        check("s5_writes",  wr_cnt[1], 0);
        check("s5_reads",   rd_cnt[1], 256);

        // ---------------- reset in the middle of a sprite ----------------
        mode = 2;
        clear_stats();
        img = 8'h02; xin = 9'd0; yin = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(ifc1.sprite_rom_re === 1'b1 && ifc1.sprite_rom_addr[7:0] == 8'd100) && n < 400) begin
            step();
            n++;
        end
        check("s6_reached_idx100", ifc1.sprite_rom_addr, 16'h0264);
        rst = 1'b1;
        step();
        check("s6_we_after_rst",  ifc1.fb_we, 0);
        check("s6_rdy_after_rst", ifc1.draw_sprite_rdy, 1);
        check("s6_re_after_rst",  ifc1.sprite_rom_re, 0);
        rst = 1'b0;
        step();
        run_sprite(8'h03, 9'd50, 8'd60, lat);
        check("s6_latency", lat, 258);
        check("s6_writes",  wr_cnt[1], 256);
        check("s6_bad",     bad_cnt[1], 0);
        check("s6_pxmin",   pxmin[1], 50);
        check("s6_pymax",   pymax[1], 75);

        // ---------------- rst and start together ----------------
        clear_stats();
        rst = 1'b1;
        start = 1'b1;
        step();
        check("s7_rdy",   ifc1.draw_sprite_rdy, 1);
        check("s7_re",    ifc1.sprite_rom_re, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) step();
        check("s7_reads", rd_cnt[1], 0);

        // ---------------- start held across two sprites ----------------
        mode = 0;
        clear_stats();
        ex_x0 = 20; ex_y0 = 30;
        img = 8'h08; xin = 9'd20; yin = 8'd30;
        check("s8_rdy_at_accept", ifc1.draw_sprite_rdy, 1);
        start = 1'b1;
        step();
        acc0 = cyc;
        check("s8_first_read", ifc1.sprite_rom_addr, 16'h0800);
        repeat (50) step();
        // New request values presented while busy must not leak in
        img = 8'h09; xin = 9'd40; yin = 8'd40;
        n = 0;
        while (ifc1.draw_sprite_rdy !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check("s8_latency", cyc - acc0 + 1, 258);
        check("s8_reads",   rd_cnt[1], 256);
        check("s8_admax",   admax[1], 16'h08FF);
        check("s8_writes",  wr_cnt[1], 256);
        check("s8_bad",     bad_cnt[1], 0);
        clear_stats();
        ex_x0 = 40; ex_y0 = 40;
        step();
        check("s8_second_read", {ifc1.sprite_rom_re, ifc1.sprite_rom_addr}, {1'b1, 16'h0900});
        check("s8_period", cyc - acc0, 258);
        start = 1'b0;
        n = 0;
        while (ifc1.draw_sprite_rdy !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check("s8_second_writes", wr_cnt[1], 256);
        check("s8_second_bad",    bad_cnt[1], 0);
        check("s8_second_pxmin",  pxmin[1], 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_draw_sprite
`default_nettype wire
